// File: rtl/mem_port_arbiter.sv
// Single memory-port arbiter between instruction fetch and load/store.
// Load/store has priority, a starvation counter forces a fetch slot, and a shift register routes read data back.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [3:0]        r_starve_cnt;
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [RD_LAT-1:0] r_own_pipe;
  logic              w_force_if;
  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_rd_push;

  // Grants are held low while reset is asserted so nothing reaches the macro.
  always_comb begin
    w_if_gnt   = 1'b0;
    w_ls_gnt   = 1'b0;
    w_force_if = (r_starve_cnt == 4'(STARVE_MAX)) && if_req;
    if (!rst) begin
      if (w_force_if)  w_if_gnt = 1'b1;
      else if (ls_req) w_ls_gnt = 1'b1;
      else if (if_req) w_if_gnt = 1'b1;
    end
  end

  assign w_rd_push = w_if_gnt | (w_ls_gnt & ~ls_we);

  always_comb begin
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    if (w_ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wren  = ls_we;
      mem_wdata = ls_wdata;
    end else if (w_if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt || !if_req) begin
      r_starve_cnt <= '0;
    end else if (w_ls_gnt && (r_starve_cnt != 4'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Tail entry lines up with mem_rdata RD_LAT cycles after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_own_pipe[i] <= r_own_pipe[i-1];
      end
      r_vld_pipe[0] <= w_rd_push;
      r_own_pipe[0] <= w_ls_gnt;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = r_vld_pipe[RD_LAT-1] & ~r_own_pipe[RD_LAT-1];
  assign ls_rvalid = r_vld_pipe[RD_LAT-1] &  r_own_pipe[RD_LAT-1];
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected returns, a monitor pops them on rvalid.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 11, DATA_W = 32, RD_LAT = 2, STARVE_MAX = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_wren;
  logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Memory macro model: registered read, RD_LAT stages, write-then-read ordering.
  logic load_mem = 1'b1;
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (load_mem) begin
      mem[11'h005] <= 32'hE3A01005;
      mem[11'h001] <= 32'h11111111;
      mem[11'h002] <= 32'h22222222;
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic own; logic [DATA_W-1:0] data; int due; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic own, input logic [DATA_W-1:0] data);
    q.push_back('{own, data, cyc + RD_LAT});
  endtask

  // One cycle of stimulus: drive just after the rising edge, return at the falling edge.
  task automatic drv(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic lr, input logic lw, input logic [ADDR_W-1:0] la,
                     input logic [DATA_W-1:0] ld);
    @(posedge clk); #1;
    rst = r; if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    @(negedge clk);
  endtask

  task automatic exp_gnt(input string nm, input logic eif, input logic els,
                         input logic [ADDR_W-1:0] ea, input logic ew);
    chk({nm, "_gnt"}, 64'({if_gnt, ls_gnt}), 64'({eif, els}));
    chk({nm, "_addr"}, 64'(mem_addr), 64'(ea));
    chk({nm, "_wren"}, 64'(mem_wren), 64'(ew));
  endtask

  // Monitor: every rvalid must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    if (if_gnt || ls_gnt) chk("gnt_excl", 64'(if_gnt & ls_gnt), 64'(0));
    if (if_rvalid || ls_rvalid) begin
      if (if_rvalid && ls_rvalid) chk("rvalid_excl", 64'(1), 64'(0));
      if (q.size() == 0) begin
        chk("unexpected_rvalid", 64'({if_rvalid, ls_rvalid}), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ret_owner", 64'(ls_rvalid), 64'(e.own));
        chk("ret_data", 64'(e.own ? ls_rdata : if_rdata), 64'(e.data));
        chk("ret_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    // Reset with both requests asserted: nothing may be granted.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      drv(1, 1, 11'h005, 1, 1, 11'h002, 32'h0);
      exp_gnt("rst_hold", 0, 0, 11'h000, 0);
    end
    load_mem = 1'b0;
    chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'(0));

    // Idle
    for (int k = 0; k < 10; k++) begin
      drv(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);
      chk("idle_outs", 64'({if_gnt, ls_gnt, mem_wren, mem_addr, mem_wdata}), 64'(0));
      chk("idle_rvalid", 64'({if_rvalid, ls_rvalid}), 64'(0));
    end

    // Fetch only
    drv(0, 1, 11'h005, 0, 0, 11'h000, 32'h0);
    exp_gnt("fetch", 1, 0, 11'h005, 0);
    push(0, 32'hE3A01005);
    for (int k = 0; k < RD_LAT + 2; k++) drv(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);

    // Store then load to the same address
    drv(0, 0, 11'h000, 1, 1, 11'h040, 32'hDEADBEEF);
    exp_gnt("store", 0, 1, 11'h040, 1);
    chk("store_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    drv(0, 0, 11'h000, 1, 0, 11'h040, 32'h0);
    exp_gnt("load", 0, 1, 11'h040, 0);
    push(1, 32'hDEADBEEF);
    for (int k = 0; k < RD_LAT + 2; k++) drv(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);

    // Contention: ls wins four times, fifth cycle forced fetch, then ls again
    for (int k = 1; k <= 8; k++) begin
      drv(0, 1, 11'h005, 1, 0, 11'h002, 32'h0);
      if (k == 5) begin
        exp_gnt("starve_if", 1, 0, 11'h005, 0);
        push(0, 32'hE3A01005);
      end else begin
        exp_gnt("starve_ls", 0, 1, 11'h002, 0);
        push(1, 32'h22222222);
      end
    end

    // Pipelined alternating fetch/load reads
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        drv(0, 1, 11'h001, 0, 0, 11'h000, 32'h0);
        exp_gnt("pipe_if", 1, 0, 11'h001, 0);
        push(0, 32'h11111111);
      end else begin
        drv(0, 0, 11'h000, 1, 0, 11'h002, 32'h0);
        exp_gnt("pipe_ls", 0, 1, 11'h002, 0);
        push(1, 32'h22222222);
      end
    end
    for (int k = 0; k < RD_LAT + 2; k++) drv(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);

    // Build starvation count to 3 with stores, issue a load, then reset mid-flight
    for (int k = 0; k < 3; k++) begin
      drv(0, 1, 11'h005, 1, 1, 11'h060, 32'h12345678);
      exp_gnt("pre_rst_st", 0, 1, 11'h060, 1);
    end
    drv(0, 1, 11'h005, 1, 0, 11'h002, 32'h0);
    exp_gnt("pre_rst_ld", 0, 1, 11'h002, 0);
    drv(1, 1, 11'h005, 1, 0, 11'h002, 32'h0);
    exp_gnt("mid_rst", 0, 0, 11'h000, 0);
    // Count must be cleared: ls keeps priority over a waiting fetch
    drv(0, 1, 11'h005, 1, 0, 11'h002, 32'h0);
    exp_gnt("post_rst_ls", 0, 1, 11'h002, 0);
    push(1, 32'h22222222);
    drv(0, 1, 11'h005, 0, 0, 11'h000, 32'h0);
    exp_gnt("post_rst_if", 1, 0, 11'h005, 0);
    push(0, 32'hE3A01005);

    for (int k = 0; k < RD_LAT + 4; k++) drv(0, 0, 11'h000, 0, 0, 11'h000, 32'h0);
    chk("drain", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single read/write port of the CPU's dual-port instruction/data memory between the instruction-fetch unit and the load/store unit. Fixed priority to load/store, with a starvation guard that forces a fetch grant after a bounded run of consecutive load/store grants. Tracks in-flight reads through the memory's fixed read latency and routes returned data to the requester that issued the read. Sits between the integrated CPU's fetch/memory stages and the memory macro.

## Interface
- ADDR_W, 11, word address width (matches start_pc width)
- DATA_W, 32, data word width
- RD_LAT, 1, memory read latency in cycles, legal 1..3
- STARVE_MAX, 4, consecutive load/store grants allowed while fetch waits, legal 1..15

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  load/store request; held with ls_we/addr/wdata until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store word address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  ls_rdata valid (loads only)
- ls_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_wren  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after address presented

## Operation
- One grant per cycle max; if_gnt and ls_gnt never both 1.
- Grant decision is combinational from current requests and registered starvation count.
- Winner: if starve_cnt == STARVE_MAX and if_req, fetch wins; else ls_req wins; else if_req wins; else no grant.
- On grant, mem_addr/mem_wren/mem_wdata driven from winner in same cycle; mem_wren = ls_gnt & ls_we. No grant: mem_addr = 0, mem_wren = 0, mem_wdata = 0.
- starve_cnt (4 bits, reset 0): increment on ls_gnt while if_req high; clear on if_gnt or when if_req low; saturates at STARVE_MAX.
- Read tracking: RD_LAT-deep shift register of {valid, owner}; entry pushed each cycle = {granted read, 0 = fetch / 1 = load}. Stores push valid = 0.
- At tail: valid & owner = 0 -> if_rvalid = 1; valid & owner = 1 -> ls_rvalid = 1. if_rdata and ls_rdata both = mem_rdata unconditionally; consumers qualify with rvalid.
- Back-to-back grants fully pipelined: throughput one access per cycle, returns in grant order.
- Store followed next cycle by load to same address: ordering guaranteed by memory port; arbiter does not forward.

## Timing
- Reset (rst high at edge): starve_cnt = 0, tracking pipeline cleared; if_gnt, ls_gnt, mem_wren forced 0 combinationally while rst high; if_rvalid, ls_rvalid = 0 the cycle after reset edge. Reads in flight at reset are dropped, never produce rvalid.
- Grant latency: 0 cycles (gnt in same cycle as req when selected).
- Read data latency: rvalid exactly RD_LAT cycles after the granting edge cycle.
- Requester dropping req before gnt: legal; no access issued.
- Simultaneous req with starve_cnt < STARVE_MAX: ls wins, fetch waits.
- Worst-case fetch wait with ls_req held continuously: STARVE_MAX cycles, granted on cycle STARVE_MAX+1.
- After forced fetch grant, starve_cnt = 0; ls regains priority next cycle.
- Request asserted while rst high is ignored; arbitration resumes first cycle after rst low.

## Test plan
- Fetch only: if_req=1, if_addr=0x005 one cycle, mem holds 0xE3A01005 -> if_gnt same cycle, mem_addr=0x005, mem_wren=0, if_rvalid=1 with if_rdata=0xE3A01005 RD_LAT cycles later, ls_rvalid never 1.
- Store then load: ls store addr 0x040 data 0xDEADBEEF, next cycle load 0x040 -> mem_wren=1 only first cycle, ls_rvalid once with 0xDEADBEEF, no rvalid for the store.
- Contention/starvation (STARVE_MAX=4): if_req and ls_req held 8 cycles -> ls_gnt cycles 1-4, if_gnt cycle 5, ls_gnt cycles 6-8; never both gnt.
- Pipelined mixed reads: alternate fetch 0x001 / load 0x002 grants 4 consecutive cycles -> four rvalids on consecutive cycles, each routed to correct requester with correct data, in grant order.
- Reset mid-flight (RD_LAT=2): grant load, assert rst next cycle -> no ls_rvalid, starve_cnt=0, all gnt 0 while rst high, normal fetch grant first cycle after rst low.
- Idle: no requests 10 cycles -> mem_addr=0, mem_wren=0, all gnt/rvalid 0.
